// File: rtl/lsu.sv
// rtl/lsu.sv - load/store stage with req/gnt/rvalid memory port; misalign trap enabled by LSU_MISALIGN_CHECK_EN
module lsu #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [3:0]            i_lsu_type,
   input  logic [DATA_WIDTH-1:0] i_alu_res,
   input  logic [DATA_WIDTH-1:0] i_rs2_data,
   input  logic [4:0]            i_rd_addr,
   input  logic                  i_rd_wen,
   output logic                  o_mem_req,
   input  logic                  i_mem_gnt,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic [3:0]            o_mem_wstrb,
   input  logic                  i_mem_rvalid,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_wb_data,
   output logic [4:0]            o_rd_addr,
   output logic                  o_rd_wen,
   output logic                  o_lsu_err
);
   localparam logic [3:0] LSU_LB  = 4'd1;
   localparam logic [3:0] LSU_LH  = 4'd2;
   localparam logic [3:0] LSU_LW  = 4'd3;
   localparam logic [3:0] LSU_LBU = 4'd4;
   localparam logic [3:0] LSU_LHU = 4'd5;
   localparam logic [3:0] LSU_SB  = 4'd8;
   localparam logic [3:0] LSU_SH  = 4'd9;
   localparam logic [3:0] LSU_SW  = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
   state_t state, state_nxt;

   logic [3:0]            type_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] rs2_q;
   logic [DATA_WIDTH-1:0] wb_q;
   logic [4:0]            rd_q;
   logic                  wen_q;
   logic                  err_q;

   logic                  in_mem;
   logic                  in_store;
   logic                  in_misalign;
   logic [1:0]            off;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [DATA_WIDTH-1:0] load_data;

   // Classify the incoming instruction as memory access and/or store
   always_comb begin
      in_mem   = 1'b0;
      in_store = 1'b0;
      case (i_lsu_type)
         LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU: in_mem = 1'b1;
         LSU_SB, LSU_SH, LSU_SW: begin
            in_mem   = 1'b1;
            in_store = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_CHECK_EN
   // Halfwords must be 2-byte aligned, words 4-byte aligned
   always_comb begin
      in_misalign = 1'b0;
      case (i_lsu_type)
         LSU_LH, LSU_LHU, LSU_SH: in_misalign = i_alu_res[0];
         LSU_LW, LSU_SW:          in_misalign = |i_alu_res[1:0];
         default: ;
      endcase
   end
`else
   assign in_misalign = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state: NONE and trapped accesses bypass the memory port
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (i_valid) state_nxt = (in_mem && !in_misalign) ? S_REQ : S_RESP;
         S_REQ:  if (i_mem_gnt) state_nxt = S_WAIT;
         S_WAIT: if (i_mem_rvalid) state_nxt = S_RESP;
         S_RESP: if (i_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      o_ready   = (state == S_IDLE);
      o_mem_req = (state == S_REQ);
      o_valid   = (state == S_RESP);
   end

   // Instruction capture and result latching
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         type_q <= '0;
         addr_q <= '0;
         rs2_q  <= '0;
         wb_q   <= '0;
         rd_q   <= '0;
         wen_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (state == S_IDLE && i_valid) begin
            type_q <= i_lsu_type;
            addr_q <= i_alu_res[ADDR_WIDTH-1:0];
            rs2_q  <= i_rs2_data;
            rd_q   <= i_rd_addr;
            wen_q  <= i_rd_wen & ~in_store & ~in_misalign;
            err_q  <= in_misalign;
            wb_q   <= in_mem ? '0 : i_alu_res;
         end
         if (state == S_WAIT && i_mem_rvalid) wb_q <= load_data;
      end
   end

   assign off    = addr_q[1:0];
   assign byte_v = i_mem_rdata[{off, 3'b000} +: 8];
   assign half_v = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];

   // Lane extraction and extension of the returned word; stores latch 0
   always_comb begin
      load_data = '0;
      case (type_q)
         LSU_LB:  load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
         LSU_LH:  load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
         LSU_LW:  load_data = i_mem_rdata;
         LSU_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
         LSU_LHU: load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
         default: load_data = '0;
      endcase
   end

   // Store lane replication and byte strobes, held from the captured instruction
   always_comb begin
      o_mem_we    = 1'b0;
      o_mem_wdata = '0;
      o_mem_wstrb = 4'b0000;
      case (type_q)
         LSU_SB: begin
            o_mem_we    = 1'b1;
            o_mem_wdata = {4{rs2_q[7:0]}};
            o_mem_wstrb = 4'b0001 << off;
         end
         LSU_SH: begin
            o_mem_we    = 1'b1;
            o_mem_wdata = {2{rs2_q[15:0]}};
            o_mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
         end
         LSU_SW: begin
            o_mem_we    = 1'b1;
            o_mem_wdata = rs2_q;
            o_mem_wstrb = 4'b1111;
         end
         default: ;
      endcase
   end

   assign o_mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign o_wb_data  = wb_q;
   assign o_rd_addr  = rd_q;
   assign o_rd_wen   = wen_q;
   assign o_lsu_err  = err_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized reference-model bench for lsu
module tb_lsu;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [3:0]  i_lsu_type = '0;
   logic [31:0] i_alu_res = '0;
   logic [31:0] i_rs2_data = '0;
   logic [4:0]  i_rd_addr = '0;
   logic        i_rd_wen = 1'b0;
   logic        o_mem_req;
   logic        i_mem_gnt = 1'b0;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_wstrb;
   logic        i_mem_rvalid = 1'b0;
   logic [31:0] i_mem_rdata = '0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_wb_data;
   logic [4:0]  o_rd_addr;
   logic        o_rd_wen;
   logic        o_lsu_err;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_lsu_type(i_lsu_type), .i_alu_res(i_alu_res), .i_rs2_data(i_rs2_data),
      .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen), .o_mem_req(o_mem_req),
      .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata(i_mem_rdata), .o_valid(o_valid), .i_ready(i_ready),
      .o_wb_data(o_wb_data), .o_rd_addr(o_rd_addr), .o_rd_wen(o_rd_wen), .o_lsu_err(o_lsu_err)
   );

   typedef struct {
      logic [31:0] wb;
      logic [4:0]  rd;
      logic        rwen;
      logic        err;
      int          lat;
      int          req_cycles;
      logic [31:0] maddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        we;
      bit          mem_stable;
      bit          resp_stable;
      bit          ready_busy;
      bit          ready_start;
      bit          done;
   } obs_t;

   // Expected behaviour derived from the instruction's architectural meaning
   function automatic void model(input logic [3:0] t, input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [31:0] rdata, input logic wen,
                                 output logic [31:0] wb, output logic rwen, output logic err,
                                 output logic memop, output logic we, output logic [31:0] maddr,
                                 output logic [31:0] wdata, output logic [3:0] wstrb);
      int unsigned off, hsel;
      logic [31:0] b, h, sb, sh;
      bit is_load, is_store, misal;
      off   = a % 4;
      hsel  = (a / 2) % 2;
      b     = (rdata >> (8 * off)) & 32'hFF;
      h     = (rdata >> (16 * hsel)) & 32'hFFFF;
      sb    = rs2 & 32'hFF;
      sh    = rs2 & 32'hFFFF;
      is_load  = (t >= 1 && t <= 5);
      is_store = (t == 8 || t == 9 || t == 10);
      misal = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      if ((t == 2 || t == 5 || t == 9) && (a % 2) == 1) misal = 1'b1;
      if ((t == 3 || t == 10) && off != 0) misal = 1'b1;
`endif
      memop = (is_load || is_store) && !misal;
      err   = misal;
      maddr = a - off;
      we    = is_store;
      wdata = 32'h0;
      wstrb = 4'h0;
      wb    = a;
      rwen  = wen;
      case (t)
         4'd1: wb = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         4'd2: wb = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         4'd3: wb = rdata;
         4'd4: wb = b;
         4'd5: wb = h;
         4'd8: begin wdata = sb * 32'h0101_0101; wstrb = 4'(1 << off); end
         4'd9: begin wdata = sh * 32'h0001_0001; wstrb = 4'(3 << (2 * hsel)); end
         4'd10: begin wdata = rs2; wstrb = 4'hF; end
         default: ;
      endcase
      if (is_store) begin wb = 32'h0; rwen = 1'b0; end
      if (misal) begin wb = 32'h0; rwen = 1'b0; end
   endfunction

   // Drives one instruction through the stage acting as memory and downstream, recording what is observed
   task automatic do_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic wen, input logic [31:0] rdata,
                        input int gd, input int rvd, input int rdyd, output obs_t o);
      int gcnt, rvcnt, rdycnt;
      bit granted, seen_req, seen_resp;
      gcnt = 0; rvcnt = 0; rdycnt = 0;
      granted = 0; seen_req = 0; seen_resp = 0;
      o.wb = '0; o.rd = '0; o.rwen = 0; o.err = 0; o.lat = 0; o.req_cycles = 0;
      o.maddr = '0; o.wdata = '0; o.wstrb = '0; o.we = 0;
      o.mem_stable = 1; o.resp_stable = 1; o.ready_busy = 0; o.done = 0;
      @(negedge i_clk);
      o.ready_start = o_ready;
      i_valid = 1'b1; i_lsu_type = t; i_alu_res = a; i_rs2_data = rs2; i_rd_addr = rd; i_rd_wen = wen;
      @(negedge i_clk);
      i_valid = 1'b0;
      i_lsu_type = 4'($urandom); i_alu_res = $urandom; i_rs2_data = $urandom;
      i_rd_addr = 5'($urandom); i_rd_wen = 1'($urandom);
      for (int cyc = 1; cyc <= 64 && !o.done; cyc++) begin
         i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_ready = 1'b0; i_mem_rdata = $urandom;
         if (o_ready) o.ready_busy = 1;
         if (o_valid) begin
            if (!seen_resp) begin
               seen_resp = 1; o.lat = cyc;
               o.wb = o_wb_data; o.rd = o_rd_addr; o.rwen = o_rd_wen; o.err = o_lsu_err;
            end else if (o_wb_data !== o.wb || o_rd_addr !== o.rd || o_rd_wen !== o.rwen || o_lsu_err !== o.err) begin
               o.resp_stable = 0;
            end
            if (rdycnt == rdyd) begin
               i_ready = 1'b1; o.done = 1;
            end else begin
               rdycnt++; i_mem_rvalid = 1'b1; i_mem_gnt = 1'b1;
            end
         end else if (o_mem_req) begin
            o.req_cycles++;
            if (!seen_req) begin
               seen_req = 1;
               o.maddr = o_mem_addr; o.wdata = o_mem_wdata; o.wstrb = o_mem_wstrb; o.we = o_mem_we;
            end else if (o_mem_addr !== o.maddr || o_mem_wdata !== o.wdata || o_mem_wstrb !== o.wstrb || o_mem_we !== o.we) begin
               o.mem_stable = 0;
            end
            if (gcnt == gd) begin
               i_mem_gnt = 1'b1; granted = 1;
            end else begin
               gcnt++; i_mem_rvalid = 1'b1;
            end
         end else if (granted) begin
            if (rvcnt == rvd) begin
               i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
            end else begin
               rvcnt++; i_mem_gnt = 1'b1;
            end
         end
         @(negedge i_clk);
      end
      i_ready = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge i_clk);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
      checks++; if ({o_valid, o_mem_req, o_mem_we, o_lsu_err, o_rd_wen} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b want 00000", {o_valid, o_mem_req, o_mem_we, o_lsu_err, o_rd_wen}); end
      checks++; if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 || o_mem_wstrb !== 4'h0) begin
         errors++; $display("FAIL reset_mem got addr %h wdata %h wstrb %h want 0", o_mem_addr, o_mem_wdata, o_mem_wstrb); end
      checks++; if (o_wb_data !== 32'h0 || o_rd_addr !== 5'h0) begin
         errors++; $display("FAIL reset_wb got wb %h rd %0d want 0", o_wb_data, o_rd_addr); end
      i_rst_n = 1'b1;
      @(negedge i_clk);
      checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release got ready %b valid %b want 1 0", o_ready, o_valid); end
   endtask

   task automatic test_none;
      obs_t o;
      do_op(4'd0, 32'h1234, 32'hDEAD_BEEF, 5'd5, 1'b1, 32'h0, 0, 0, 0, o);
      checks++; if (!o.done || o.lat != 1) begin errors++; $display("FAIL none_latency got %0d want 1", o.lat); end
      checks++; if (o.wb !== 32'h1234 || o.rd !== 5'd5 || o.rwen !== 1'b1) begin
         errors++; $display("FAIL none_result got wb %h rd %0d wen %b want 00001234 5 1", o.wb, o.rd, o.rwen); end
      checks++; if (o.req_cycles != 0) begin errors++; $display("FAIL none_noreq got %0d want 0", o.req_cycles); end
   endtask

   task automatic test_sign_ext;
      obs_t o;
      do_op(4'd1, 32'h103, 32'h0, 5'd7, 1'b1, 32'h80FF_FF7F, 0, 0, 0, o);
      checks++; if (o.maddr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h want 00000100", o.maddr); end
      checks++; if (o.wb !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext got %h want ffffff80", o.wb); end
      checks++; if (!o.done || o.lat != 3) begin errors++; $display("FAIL lb_latency got %0d want 3", o.lat); end
      checks++; if (o.we !== 1'b0 || o.wstrb !== 4'h0) begin errors++; $display("FAIL lb_strb got we %b wstrb %b want 0 0000", o.we, o.wstrb); end
   endtask

   task automatic test_zero_ext;
      obs_t o;
      do_op(4'd5, 32'h202, 32'h0, 5'd9, 1'b1, 32'hBEEF_0000, 0, 1, 0, o);
      checks++; if (o.wb !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_zext got %h want 0000beef", o.wb); end
      checks++; if (o.maddr !== 32'h200) begin errors++; $display("FAIL lhu_addr got %h want 00000200", o.maddr); end
   endtask

   task automatic test_store_stall;
      obs_t o;
      do_op(4'd8, 32'h301, 32'h0000_00AB, 5'd3, 1'b1, 32'h0, 3, 0, 0, o);
      checks++; if (o.req_cycles != 4) begin errors++; $display("FAIL sb_req_cycles got %0d want 4", o.req_cycles); end
      checks++; if (o.wdata !== 32'hABAB_ABAB || o.wstrb !== 4'b0010 || o.we !== 1'b1) begin
         errors++; $display("FAIL sb_lanes got wdata %h wstrb %b we %b want abababab 0010 1", o.wdata, o.wstrb, o.we); end
      checks++; if (!o.mem_stable) begin errors++; $display("FAIL sb_req_stable got unstable want stable"); end
      checks++; if (o.rwen !== 1'b0) begin errors++; $display("FAIL sb_rd_wen got %b want 0", o.rwen); end
   endtask

   task automatic test_backpressure;
      obs_t o;
      do_op(4'd3, 32'h500, 32'h0, 5'd11, 1'b1, 32'h1357_9BDF, 1, 1, 4, o);
      checks++; if (!o.resp_stable) begin errors++; $display("FAIL bp_stable got unstable want stable"); end
      checks++; if (o.wb !== 32'h1357_9BDF) begin errors++; $display("FAIL bp_data got %h want 13579bdf", o.wb); end
      checks++; if (!o.done || o.lat != 5) begin errors++; $display("FAIL bp_latency got %0d want 5", o.lat); end
   endtask

   task automatic test_reset_mid;
      @(negedge i_clk);
      i_valid = 1'b1; i_lsu_type = 4'd3; i_alu_res = 32'h600; i_rd_addr = 5'd2; i_rd_wen = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0; i_mem_gnt = 1'b1;
      @(negedge i_clk);
      i_mem_gnt = 1'b0;
      checks++; if (o_ready !== 1'b0 || o_mem_req !== 1'b0) begin
         errors++; $display("FAIL wait_state got ready %b req %b want 0 0", o_ready, o_mem_req); end
      #1 i_rst_n = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_wait got valid %b ready %b want 0 1", o_valid, o_ready); end
      @(negedge i_clk);
      i_rst_n = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         errors++; $display("FAIL stale_rvalid got valid %b ready %b want 0 1", o_valid, o_ready); end
      i_valid = 1'b1; i_lsu_type = 4'd0; i_alu_res = 32'h77;
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      #1 i_rst_n = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_wb_data !== 32'h0) begin
         errors++; $display("FAIL reset_in_resp got valid %b ready %b wb %h want 0 1 0", o_valid, o_ready, o_wb_data); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_misalign;
      obs_t o;
      do_op(4'd3, 32'h402, 32'h0, 5'd4, 1'b1, 32'h1122_3344, 0, 0, 0, o);
`ifdef LSU_MISALIGN_CHECK_EN
      checks++; if (o.req_cycles != 0) begin errors++; $display("FAIL misalign_noreq got %0d want 0", o.req_cycles); end
      checks++; if (o.err !== 1'b1 || !o.done || o.lat != 1) begin
         errors++; $display("FAIL misalign_err got err %b lat %0d want 1 1", o.err, o.lat); end
      checks++; if (o.wb !== 32'h0 || o.rwen !== 1'b0) begin
         errors++; $display("FAIL misalign_wb got wb %h wen %b want 0 0", o.wb, o.rwen); end
`else
      checks++; if (o.maddr !== 32'h400 || o.req_cycles != 1) begin
         errors++; $display("FAIL misalign_off_addr got %h req %0d want 00000400 1", o.maddr, o.req_cycles); end
      checks++; if (o.err !== 1'b0 || o.wb !== 32'h1122_3344) begin
         errors++; $display("FAIL misalign_off_wb got err %b wb %h want 0 11223344", o.err, o.wb); end
`endif
   endtask

   task automatic test_random;
      logic [3:0] types [12];
      types = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd6, 4'd12, 4'd15};
      for (int n = 0; n < 60; n++) begin
         obs_t o;
         logic [3:0] t;
         logic [31:0] a, rs2, rdata, ewb, emaddr, ewdata;
         logic [4:0] rd;
         logic wen, erwen, eerr, ememop, ewe;
         logic [3:0] ewstrb;
         int gd, rvd, rdyd, elat;
         t = types[$urandom_range(0, 11)];
         a = $urandom; rs2 = $urandom; rdata = $urandom;
         rd = 5'($urandom); wen = 1'($urandom);
         gd = $urandom_range(0, 3); rvd = $urandom_range(0, 2); rdyd = $urandom_range(0, 3);
         model(t, a, rs2, rdata, wen, ewb, erwen, eerr, ememop, ewe, emaddr, ewdata, ewstrb);
         elat = ememop ? 3 + gd + rvd : 1;
         do_op(t, a, rs2, rd, wen, rdata, gd, rvd, rdyd, o);
         checks++; if (!o.done || o.lat != elat) begin
            errors++; $display("FAIL rnd%0d_latency type %0d got %0d want %0d", n, t, o.lat, elat); end
         checks++; if (o.wb !== ewb || o.rd !== rd || o.rwen !== erwen || o.err !== eerr) begin
            errors++; $display("FAIL rnd%0d_result type %0d addr %h got wb %h rd %0d wen %b err %b want %h %0d %b %b",
                               n, t, a, o.wb, o.rd, o.rwen, o.err, ewb, rd, erwen, eerr); end
         checks++; if (o.req_cycles != (ememop ? gd + 1 : 0)) begin
            errors++; $display("FAIL rnd%0d_req_cycles got %0d want %0d", n, o.req_cycles, ememop ? gd + 1 : 0); end
         if (ememop) begin
            checks++; if (o.maddr !== emaddr || o.we !== ewe || o.wstrb !== ewstrb || !o.mem_stable) begin
               errors++; $display("FAIL rnd%0d_mem type %0d got addr %h we %b wstrb %b stable %0d want %h %b %b 1",
                                  n, t, o.maddr, o.we, o.wstrb, o.mem_stable, emaddr, ewe, ewstrb); end
            if (ewe) begin
               checks++; if (o.wdata !== ewdata) begin
                  errors++; $display("FAIL rnd%0d_wdata type %0d got %h want %h", n, t, o.wdata, ewdata); end
            end
         end
         checks++; if (!o.resp_stable || o.ready_busy || !o.ready_start) begin
            errors++; $display("FAIL rnd%0d_handshake got stable %0d busy_ready %0d start_ready %0d want 1 0 1",
                               n, o.resp_stable, o.ready_busy, o.ready_start); end
      end
   endtask

   initial begin
      repeat (3) @(negedge i_clk);
      test_reset;
      test_none;
      test_sign_ext;
      test_zero_ext;
      test_store_stall;
      test_backpressure;
      test_reset_mid;
      test_misalign;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
